// File: rtl/hadamard_pkg.sv
// Shared definitions for the sequential Hadamard multiplier.
//   state_t   : FSM states (IDLE, RUN, DONE)
//   n_elem    : number of matrix elements, H*W
//   n_beats   : number of RUN beats, H*W/LANES
//   idx_width : counter/index width that stays at least 1 bit wide
package hadamard_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int n_elem(input int h, input int w);
        return h * w;
    endfunction

    function automatic int n_beats(input int h, input int w, input int lanes);
        return (h * w) / lanes;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fx_mul_sat.sv
// Combinational signed fixed-point multiply with round-half-up and saturation.
//   a, b : signed operands, DATA_WIDTH bits with FRACT_WIDTH fractional bits
//   y    : round_half_up(a*b / 2^FRACT_WIDTH), clamped to the DATA_WIDTH range
module fx_mul_sat #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);

    // One spare bit above the full product so the rounding add cannot wrap.
    localparam int PW = 2 * DATA_WIDTH + 1;

    localparam logic signed [PW-1:0] RND   = PW'(1) << (FRACT_WIDTH - 1);
    localparam logic signed [PW-1:0] MAX_V = {{(DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] MIN_V = {{(DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [PW-1:0] a_x;
    logic signed [PW-1:0] b_x;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;

    assign a_x     = {{(DATA_WIDTH+1){a[DATA_WIDTH-1]}}, a};
    assign b_x     = {{(DATA_WIDTH+1){b[DATA_WIDTH-1]}}, b};
    assign prod    = a_x * b_x;
    // Arithmetic shift floors, so adding half an LSB first gives round-half-up.
    assign shifted = (prod + RND) >>> FRACT_WIDTH;

    always_comb begin
        if (shifted > MAX_V) begin
            y = MAX_V[DATA_WIDTH-1:0];
        end else if (shifted < MIN_V) begin
            y = MIN_V[DATA_WIDTH-1:0];
        end else begin
            y = shifted[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/matrix_hadamard_seq.sv
// Sequential element-wise product y = a (.) b over an HxW signed fixed-point
// matrix, LANES elements per cycle.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   start    : request, sampled only in IDLE
//   a, b     : operand matrices, element e = i*W+j at [e*DATA_WIDTH +: DATA_WIDTH]
//   busy     : high while the FSM is in RUN
//   done     : one-cycle pulse, y holds the complete result
//   y        : result matrix, same packing; filled beat by beat during RUN
//
// Handshake: a start seen in IDLE is accepted in that cycle and a/b are
// latched; start is ignored (not queued) in RUN and DONE. done pulses for
// exactly one cycle N_BEATS+1 cycles after the accept, and y then stays
// stable until the next accepted start.
module matrix_hadamard_seq
    import hadamard_pkg::*;
#(
    parameter int H           = 8,
    parameter int W           = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8,
    parameter int LANES       = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [H*W*DATA_WIDTH-1:0]     a,
    input  logic [H*W*DATA_WIDTH-1:0]     b,
    output logic                          busy,
    output logic                          done,
    output logic [H*W*DATA_WIDTH-1:0]     y
);

    localparam int N_ELEM  = n_elem(H, W);
    localparam int N_BEATS = n_beats(H, W, LANES);
    localparam int EW      = idx_width(N_ELEM);
    localparam int BW      = idx_width(N_BEATS);

    localparam logic [BW-1:0] LAST_BEAT = BW'(N_BEATS - 1);

    if ((H * W) % LANES != 0) begin : g_bad_lanes
        $error("matrix_hadamard_seq: H*W must be a multiple of LANES");
    end

    state_t                  state;
    logic [BW-1:0]           beat;
    logic [DATA_WIDTH-1:0]   a_q [N_ELEM];
    logic [DATA_WIDTH-1:0]   b_q [N_ELEM];
    logic [DATA_WIDTH-1:0]   y_q [N_ELEM];

    logic [EW-1:0]           lane_idx [LANES];
    logic [DATA_WIDTH-1:0]   lane_a   [LANES];
    logic [DATA_WIDTH-1:0]   lane_b   [LANES];
    logic [DATA_WIDTH-1:0]   lane_y   [LANES];

    // Lane l of beat k handles element k*LANES + l.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = EW'(int'(beat) * LANES + l);
        assign lane_a[l]   = a_q[lane_idx[l]];
        assign lane_b[l]   = b_q[lane_idx[l]];

        fx_mul_sat #(
            .DATA_WIDTH  (DATA_WIDTH),
            .FRACT_WIDTH (FRACT_WIDTH)
        ) u_mul (
            .a (lane_a[l]),
            .b (lane_b[l]),
            .y (lane_y[l])
        );
    end

    for (genvar e = 0; e < N_ELEM; e++) begin : g_pack
        assign y[e*DATA_WIDTH +: DATA_WIDTH] = y_q[e];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            beat  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            for (int e = 0; e < N_ELEM; e++) begin
                a_q[e] <= '0;
                b_q[e] <= '0;
                y_q[e] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        for (int e = 0; e < N_ELEM; e++) begin
                            a_q[e] <= a[e*DATA_WIDTH +: DATA_WIDTH];
                            b_q[e] <= b[e*DATA_WIDTH +: DATA_WIDTH];
                        end
                        beat  <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int l = 0; l < LANES; l++) begin
                        y_q[lane_idx[l]] <= lane_y[l];
                    end
                    if (beat == LAST_BEAT) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        beat <= beat + BW'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_hadamard_seq.sv
// Bench for matrix_hadamard_seq: a 2x2 single-lane instance driven by a
// table of hand-computed Q8.8 vectors plus multi-cycle corner sequences,
// and an 8x8 four-lane instance checked against a behavioural model.
module tb_matrix_hadamard_seq;

    localparam int DW      = 16;
    localparam int BIG_E   = 64;
    localparam int BIG_BITS = BIG_E * DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- DUT 0: 2x2, LANES=1 ----------------
    logic        start0;
    logic [63:0] a0, b0, y0;
    logic        busy0, done0;

    matrix_hadamard_seq #(
        .H(2), .W(2), .DATA_WIDTH(16), .FRACT_WIDTH(8), .LANES(1)
    ) u_small (
        .clk   (clk),
        .rst   (rst),
        .start (start0),
        .a     (a0),
        .b     (b0),
        .busy  (busy0),
        .done  (done0),
        .y     (y0)
    );

    // ---------------- DUT 1: 8x8, LANES=4 ----------------
    logic                start1;
    logic [BIG_BITS-1:0] a1, b1, y1;
    logic                busy1, done1;

    matrix_hadamard_seq #(
        .H(8), .W(8), .DATA_WIDTH(16), .FRACT_WIDTH(8), .LANES(4)
    ) u_big (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .y     (y1)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [BIG_BITS-1:0] act,
                         input logic [BIG_BITS-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural reference: exact integer product, round half up, clamp.
    function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] z);
        longint p;
        p = longint'($signed(x)) * longint'($signed(z)) + 64'sd128;
        p = p >>> 8;
        if (p > 64'sd32767)  return 16'h7FFF;
        if (p < -64'sd32768) return 16'h8000;
        return p[15:0];
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] y;
    } vec_t;

    vec_t vecs [4];

    // ---------------- driver tasks ----------------
    // Accepts one matrix on DUT 0 and follows it until done or budget expiry.
    // done_c is the cycle offset of done relative to the accept cycle.
    task automatic run_small(input logic [63:0] a, input logic [63:0] b,
                             output logic [63:0] y_done, output int done_c,
                             output int busy_n);
        @(negedge clk);
        a0 = a; b0 = b; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        done_c = -1; busy_n = 0; y_done = '0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk);
            busy_n += int'(busy0);
            if (done0) begin
                done_c = c;
                y_done = y0;
                break;
            end
        end
    endtask

    task automatic run_big(input logic [BIG_BITS-1:0] a, input logic [BIG_BITS-1:0] b,
                           output logic [BIG_BITS-1:0] y_done, output int done_c,
                           output int busy_n);
        @(negedge clk);
        a1 = a; b1 = b; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        done_c = -1; busy_n = 0; y_done = '0;
        for (int c = 1; c <= 60; c++) begin
            if (c > 1) @(negedge clk);
            busy_n += int'(busy1);
            if (done1) begin
                done_c = c;
                y_done = y1;
                break;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0]         ys;
        logic [BIG_BITS-1:0] ab, bb, eb, yb;
        int                  dc, bn, dn;

        // Element 0 is the rightmost 16-bit field.
        vecs[0] = '{"identity", 64'h0100_0100_0100_0100,
                    64'h0000_0200_FF80_0080, 64'h0000_0200_FF80_0080};
        vecs[1] = '{"saturate", 64'h0100_8000_8000_7FFF,
                    64'h0100_8000_7FFF_7FFF, 64'h0100_7FFF_8000_7FFF};
        vecs[2] = '{"rounding", 64'h0002_FFFF_FFFF_0001,
                    64'hFF00_0180_0080_0080, 64'hFFFE_FFFF_0000_0001};
        vecs[3] = '{"mixed",    64'h0003_0040_FE00_0180,
                    64'h0003_0040_0300_0280, 64'h0000_0010_FA00_03C0};

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        check("reset_y0",    y0,    '0);
        check("reset_busy0", busy0, '0);
        check("reset_done0", done0, '0);
        check("reset_y1",    y1,    '0);
        check("reset_busy1", busy1, '0);
        rst = 1'b0;

        // Table-driven vectors: result, done latency (N+1 = 5), busy length (N = 4).
        for (int i = 0; i < 4; i++) begin
            run_small(vecs[i].a, vecs[i].b, ys, dc, bn);
            check({vecs[i].name, "_y"},    ys, vecs[i].y);
            check({vecs[i].name, "_done"}, dc, 5);
            check({vecs[i].name, "_busy"}, bn, 4);
            @(negedge clk);
            check({vecs[i].name, "_pulse"}, done0, '0);
            check({vecs[i].name, "_idle"},  busy0, '0);
        end

        // start re-pulsed in RUN with new operands, and again in DONE: both ignored.
        @(negedge clk);
        a0 = vecs[3].a; b0 = vecs[3].b; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        dc = -1; dn = 0; ys = '0;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) @(negedge clk);
            if (done0) begin
                dn++;
                if (dc < 0) begin dc = c; ys = y0; end
            end
            if (c == 2) begin
                start0 = 1'b1;
                a0 = {$urandom, $urandom};
                b0 = {$urandom, $urandom};
            end
            if (c == 3) start0 = 1'b0;
            if (c == 5) start0 = 1'b1;
            if (c == 6) start0 = 1'b0;
        end
        check("restart_y",     ys,    vecs[3].y);
        check("restart_done",  dc,    5);
        check("restart_count", dn,    1);
        check("restart_busy",  busy0, '0);

        // Reset on beat 2 of a 4-beat run aborts with y cleared and no done.
        @(negedge clk);
        a0 = vecs[1].a; b0 = vecs[1].b; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        dn = 0;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) @(negedge clk);
            dn += int'(done0);
            if (c == 3) rst = 1'b1;
            if (c == 4) begin
                check("abort_busy", busy0, '0);
                check("abort_y",    y0,    '0);
                rst = 1'b0;
            end
        end
        check("abort_nodone", dn, 0);
        run_small(vecs[2].a, vecs[2].b, ys, dc, bn);
        check("after_abort_y",    ys, vecs[2].y);
        check("after_abort_done", dc, 5);

        // rst and start together: start is dropped.
        @(negedge clk);
        rst = 1'b1; start0 = 1'b1; a0 = vecs[0].a; b0 = vecs[0].b;
        @(negedge clk);
        rst = 1'b0; start0 = 1'b0;
        check("rst_start_busy", busy0, '0);
        @(negedge clk);
        check("rst_start_busy2", busy0, '0);
        check("rst_start_y",     y0,    '0);

        // 8x8, 4 lanes: model comparison, done at t+17, busy for 16 cycles.
        for (int r = 0; r < 3; r++) begin
            for (int e = 0; e < BIG_E; e++) begin
                logic [15:0] av, bv;
                av = 16'($urandom_range(0, 65535));
                bv = 16'($urandom_range(0, 65535));
                if (e % 13 == 0) av = 16'h8000;
                if (e % 17 == 0) bv = 16'h7FFF;
                if (r == 2 && e % 2 == 0) begin
                    av = 16'($urandom_range(0, 1023)) - 16'd512;
                    bv = 16'($urandom_range(0, 1023)) - 16'd512;
                end
                ab[e*DW +: DW] = av;
                bb[e*DW +: DW] = bv;
                eb[e*DW +: DW] = ref_mul(av, bv);
            end
            run_big(ab, bb, yb, dc, bn);
            check($sformatf("big%0d_y", r),    yb, eb);
            check($sformatf("big%0d_done", r), dc, 17);
            check($sformatf("big%0d_busy", r), bn, 16);
            @(negedge clk);
            check($sformatf("big%0d_pulse", r), done1, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
